// File: rtl/instr_fetch_unit_pkg.sv
// Shared constants and payload types for the instruction fetch unit.
package instr_fetch_unit_pkg;

    localparam logic [31:0] IFU_RESET_PC     = 32'h0000_0000;
    localparam int unsigned IFU_FIFO_DEPTH   = 2;
    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam int unsigned FETCH_WORD_BYTES = 4;

    // Instruction buffer entry; pc occupies the upper half.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } fetch_entry_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Fetch-stage bus bundle: imem request/response, decode handshake and redirect.
interface instr_fetch_unit_if;

    logic        imem_req_valid;
    logic        imem_req_ready;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid;
    logic [31:0] imem_rsp_data;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_data;
    logic [31:0] inst_pc;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        fetch_fault;

    modport master (
        output imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
    );

    modport slave (
        input  imem_req_valid, imem_req_addr, inst_valid, inst_data, inst_pc, fetch_fault,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/instr_fetch_unit_fetch_fifo.sv
// Synchronous FIFO with flush; head is read combinationally from the storage array.
module instr_fetch_unit_fetch_fifo #(
    parameter int unsigned WIDTH = 64,
    parameter int unsigned DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_flush,
    input  logic                  i_push,
    input  logic                  i_pop,
    input  logic [WIDTH-1:0]      i_data,
    output logic [WIDTH-1:0]      o_data,
    output logic [$clog2(DEPTH):0] o_count,
    output logic                  o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < DEPTH; i++) r_mem[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= r_wr_ptr + AW'(1);
            end
            if (i_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_data  = r_mem[r_rd_ptr];
    assign o_count = r_count;
    assign o_empty = (r_count == '0);

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues credit-limited imem fetches, buffers words in order.
// Build option: define IFU_MISALIGN_CHECK_EN to fault and halt on misaligned redirect targets.
module instr_fetch_unit
    import instr_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC   = IFU_RESET_PC,
    parameter int unsigned FIFO_DEPTH = IFU_FIFO_DEPTH
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);

    localparam int unsigned AW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W = AW + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      r_pc;
    logic [CNT_W-1:0] r_outstanding;
    logic [CNT_W-1:0] r_drop_cnt;
    logic             r_active;
    logic [31:0]      r_tag_mem [FIFO_DEPTH];
    logic [AW-1:0]    r_tag_wr;
    logic [AW-1:0]    r_tag_rd;

    logic [CNT_W-1:0] w_fifo_count;
    logic             w_fifo_empty;
    logic             w_fault_hold;
    logic             w_credit;
    logic             w_req_valid;
    logic             w_req_fire;
    logic             w_rsp_keep;
    logic             w_inst_valid;
    logic             w_pop;
    logic             w_redirect;
    logic [31:0]      w_redirect_tgt;
    fetch_entry_t     w_push_entry;
    fetch_entry_t     w_head;

    assign w_redirect     = bus.redirect_valid;
    assign w_redirect_tgt = bus.redirect_pc & ~32'd3;

    // Requests in flight plus buffered words may never exceed the buffer size.
    assign w_credit    = (SUM_W'(r_outstanding) + SUM_W'(w_fifo_count)) < SUM_W'(FIFO_DEPTH);
    assign w_req_valid = r_active && w_credit && !w_redirect && (r_drop_cnt == '0) && !w_fault_hold;
    assign w_req_fire  = w_req_valid && bus.imem_req_ready;
    assign w_rsp_keep  = bus.imem_rsp_valid && !w_redirect && (r_drop_cnt == '0);
    assign w_inst_valid = !w_fifo_empty && !w_redirect;
    assign w_pop        = w_inst_valid && bus.inst_ready;

`ifdef IFU_MISALIGN_CHECK_EN
    logic r_fault;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)          r_fault <= 1'b0;
        else if (w_redirect) r_fault <= |bus.redirect_pc[1:0];
    end

    assign w_fault_hold    = r_fault;
    assign bus.fetch_fault = r_fault;
`else
    assign w_fault_hold    = 1'b0;
    assign bus.fetch_fault = 1'b0;
`endif

    // PC, in-flight count and the number of stale responses still to be discarded.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc          <= RESET_PC;
            r_outstanding <= '0;
            r_drop_cnt    <= '0;
            r_active      <= 1'b0;
        end else begin
            r_active      <= 1'b1;
            r_outstanding <= r_outstanding + CNT_W'(w_req_fire) - CNT_W'(bus.imem_rsp_valid);
            if (w_redirect) begin
                r_pc       <= w_redirect_tgt;
                r_drop_cnt <= r_outstanding - CNT_W'(bus.imem_rsp_valid);
            end else begin
                if (w_req_fire) r_pc <= r_pc + 32'(FETCH_WORD_BYTES);
                if (bus.imem_rsp_valid && (r_drop_cnt != '0))
                    r_drop_cnt <= r_drop_cnt - CNT_W'(1);
            end
        end
    end

    // In-order queue of request addresses used to tag kept responses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < FIFO_DEPTH; i++) r_tag_mem[i] <= '0;
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else if (w_redirect) begin
            r_tag_wr <= '0;
            r_tag_rd <= '0;
        end else begin
            if (w_req_fire) begin
                r_tag_mem[r_tag_wr] <= r_pc;
                r_tag_wr            <= r_tag_wr + AW'(1);
            end
            if (w_rsp_keep) r_tag_rd <= r_tag_rd + AW'(1);
        end
    end

    assign w_push_entry = '{pc: r_tag_mem[r_tag_rd], inst: bus.imem_rsp_data};

    instr_fetch_unit_fetch_fifo #(
        .WIDTH ($bits(fetch_entry_t)),
        .DEPTH (FIFO_DEPTH)
    ) u_inst_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (w_redirect),
        .i_push  (w_rsp_keep),
        .i_pop   (w_pop),
        .i_data  (w_push_entry),
        .o_data  (w_head),
        .o_count (w_fifo_count),
        .o_empty (w_fifo_empty)
    );

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = w_inst_valid;
    assign bus.inst_data      = w_head.inst;
    assign bus.inst_pc        = w_head.pc;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit against a transaction-level fetch/redirect model.
module tb_instr_fetch_unit;

    localparam int unsigned DEPTH  = 2;
    localparam logic [31:0] RST_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] addr;
        int          epoch;
        int          due;
    } mreq_t;

    logic clk = 1'b0;
    logic rst_n;

    instr_fetch_unit_if bus();

    instr_fetch_unit #(
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int          n_vec;
    int          n_err;
    int          cyc;
    int          since_rst;
    int          lat;
    int          rdy_pct;
    int          irdy_pct;
    int          epoch;
    int          buffered;
    int          fires;
    bit          fault_exp;
    bit          redir;
    logic [31:0] redir_pc;
    logic [31:0] exp_pc;
    logic [31:0] exp_req;
    bit          held;
    logic [31:0] held_pc;
    logic [31:0] held_data;
    mreq_t       mq[$];
    logic [31:0] dlv_q[$];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    function automatic logic [31:0] memfn(input logic [31:0] a);
        return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    function automatic logic [31:0] dlv_at(input int i);
        if (i < dlv_q.size()) return dlv_q[i];
        return 32'hDEAD_BEEF;
    endfunction

    // Reset DUT and the memory/model side together, checking reset outputs.
    task automatic do_reset();
        rst_n              = 1'b0;
        bus.imem_req_ready = 1'b0;
        bus.imem_rsp_valid = 1'b0;
        bus.imem_rsp_data  = '0;
        bus.inst_ready     = 1'b0;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        mq.delete();
        buffered  = 0;
        epoch     = 0;
        fault_exp = 1'b0;
        redir     = 1'b0;
        held      = 1'b0;
        exp_pc    = RST_PC;
        exp_req   = RST_PC;
        #2;
        check_val("rst_req_valid", 32'(bus.imem_req_valid), 32'd0);
        check_val("rst_req_addr",  bus.imem_req_addr, RST_PC);
        check_val("rst_inst_valid", 32'(bus.inst_valid), 32'd0);
        check_val("rst_inst_data", bus.inst_data, 32'd0);
        check_val("rst_inst_pc",   bus.inst_pc, 32'd0);
        check_val("rst_fault",     32'(bus.fetch_fault), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        since_rst = 0;
    endtask

    // One clock: drive memory/decode/redirect, check against the model, advance.
    task automatic step();
        bit    rsp_now;
        bit    fire;
        bit    pop;
        int    stale;
        logic  exp_rv;
        logic  exp_iv;
        mreq_t h;
        rsp_now = (mq.size() > 0) && (mq[0].due <= cyc);
        bus.imem_rsp_valid = rsp_now;
        bus.imem_rsp_data  = rsp_now ? memfn(mq[0].addr) : $urandom();
        bus.imem_req_ready = ($urandom_range(99) < rdy_pct);
        bus.inst_ready     = ($urandom_range(99) < irdy_pct);
        bus.redirect_valid = redir;
        bus.redirect_pc    = redir_pc;
        #1;
        stale = 0;
        foreach (mq[k]) if (mq[k].epoch != epoch) stale++;
        exp_iv = (buffered > 0) && !redir;
        check_val("inst_valid", 32'(bus.inst_valid), 32'(exp_iv));
        check_val("fetch_fault", 32'(bus.fetch_fault), 32'(fault_exp));
        if (since_rst > 0) begin
            exp_rv = ((mq.size() + buffered) < DEPTH) && !redir && (stale == 0) && !fault_exp;
            check_val("req_valid", 32'(bus.imem_req_valid), 32'(exp_rv));
        end
        if (held && bus.inst_valid) begin
            check_val("hold_pc", bus.inst_pc, held_pc);
            check_val("hold_data", bus.inst_data, held_data);
        end
        fire = bus.imem_req_valid && bus.imem_req_ready;
        pop  = bus.inst_valid && bus.inst_ready;
        if (fire) begin
            check_val("req_addr", bus.imem_req_addr, exp_req);
            h.addr  = bus.imem_req_addr;
            h.epoch = epoch;
            h.due   = cyc + lat;
            mq.push_back(h);
            exp_req = exp_req + 32'd4;
            fires++;
        end
        if (pop) begin
            check_val("inst_pc", bus.inst_pc, exp_pc);
            check_val("inst_data", bus.inst_data, memfn(exp_pc));
            dlv_q.push_back(bus.inst_pc);
            exp_pc = exp_pc + 32'd4;
            if (buffered > 0) buffered--;
        end
        held      = bus.inst_valid && !bus.inst_ready;
        held_pc   = bus.inst_pc;
        held_data = bus.inst_data;
        if (rsp_now) begin
            h = mq.pop_front();
            if (!redir && (h.epoch == epoch)) buffered++;
        end
        if (redir) begin
            buffered = 0;
            epoch++;
            exp_pc  = redir_pc & ~32'd3;
            exp_req = redir_pc & ~32'd3;
            held    = 1'b0;
`ifdef IFU_MISALIGN_CHECK_EN
            fault_exp = (redir_pc[1:0] != 2'b00);
`endif
        end
        @(posedge clk);
        #1;
        cyc++;
        since_rst++;
    endtask

    task automatic redirect_to(input logic [31:0] tgt);
        redir    = 1'b1;
        redir_pc = tgt;
        step();
        redir    = 1'b0;
    endtask

    initial begin
        bit found;
        int dlv_before;
        n_vec = 0; n_err = 0; cyc = 0; since_rst = 0; fires = 0;
        lat = 1; rdy_pct = 100; irdy_pct = 100;
        redir = 1'b0; redir_pc = '0;

        // Sequential delivery from reset with single-cycle memory.
        do_reset();
        dlv_q.delete();
        repeat (12) step();
        check_val("t1_count", 32'(dlv_q.size() >= 4), 32'd1);
        for (int i = 0; i < 4; i++) check_val($sformatf("t1_pc%0d", i), dlv_at(i), 32'(i * 4));

        // Decode stalled: credit stops fetching at the buffer size.
        do_reset();
        irdy_pct = 0;
        fires    = 0;
        repeat (6) step();
        check_val("t2_fires", 32'(fires), 32'(DEPTH));
        irdy_pct = 100;
        dlv_q.delete();
        repeat (10) step();
        for (int i = 0; i < 3; i++) check_val($sformatf("t2_pc%0d", i), dlv_at(i), 32'(i * 4));

        // Redirect with two stale responses in flight.
        do_reset();
        lat = 3;
        repeat (2) step();
        check_val("t3_outstanding", 32'(mq.size()), 32'd2);
        dlv_q.delete();
        redirect_to(32'h0000_0100);
        repeat (15) step();
        check_val("t3_pc0", dlv_at(0), 32'h0000_0100);
        check_val("t3_pc1", dlv_at(1), 32'h0000_0104);

        // Redirect coinciding with a response and a ready decode.
        do_reset();
        lat   = 1;
        found = 1'b0;
        for (int i = 0; i < 40 && !found; i++) begin
            if ((buffered > 0) && (mq.size() > 0) && (mq[0].due <= cyc)) begin
                found = 1'b1;
                dlv_q.delete();
                redirect_to(32'h0000_0400);
            end else begin
                step();
            end
        end
        check_val("t4_hit", 32'(found), 32'd1);
        repeat (10) step();
        check_val("t4_pc0", dlv_at(0), 32'h0000_0400);

        // PC wraps past the top of the address space.
        dlv_q.delete();
        redirect_to(32'hFFFF_FFF8);
        repeat (15) step();
        check_val("t5_pc0", dlv_at(0), 32'hFFFF_FFF8);
        check_val("t5_pc1", dlv_at(1), 32'hFFFF_FFFC);
        check_val("t5_pc2", dlv_at(2), 32'h0000_0000);

        // Misaligned redirect target.
        dlv_q.delete();
        redirect_to(32'h0000_0102);
        fires = 0;
        repeat (8) step();
`ifdef IFU_MISALIGN_CHECK_EN
        check_val("t6_fault_set", 32'(bus.fetch_fault), 32'd1);
        check_val("t6_no_fetch", 32'(fires), 32'd0);
        check_val("t6_no_inst", 32'(dlv_q.size()), 32'd0);
        redirect_to(32'h0000_0200);
        repeat (10) step();
        check_val("t6_fault_clr", 32'(bus.fetch_fault), 32'd0);
        check_val("t6_pc0", dlv_at(0), 32'h0000_0200);
`else
        check_val("t6_fault_zero", 32'(bus.fetch_fault), 32'd0);
        check_val("t6_pc0", dlv_at(0), 32'h0000_0100);
`endif

        // Random traffic, redirects and a mid-run reset.
        rdy_pct  = 70;
        irdy_pct = 60;
        dlv_before = dlv_q.size();
        for (int i = 0; i < 1500; i++) begin
            if (i == 800) do_reset();
            lat      = $urandom_range(1, 4);
            redir    = ($urandom_range(99) < 4);
            redir_pc = $urandom();
            if ($urandom_range(9) != 0) redir_pc[1:0] = 2'b00;
            step();
        end
        redir = 1'b0;
        check_val("rand_progress", 32'((dlv_q.size() - dlv_before) > 100), 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
